// File: rtl/fifo_row_ctrl_if.sv
// Handshake/strobe bundle between the FIFO requester and the row pointer controller.
interface fifo_row_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
);
  logic             wr_en;
  logic             rd_en;
  logic [DEPTH-1:0] ws;
  logic [DEPTH-1:0] rs;
  logic [DEPTH-1:0] oe;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             ovf;
  logic             udf;

  modport master (
    output wr_en, rd_en,
    input  ws, rs, oe, full, empty, count, ovf, udf
  );

  modport slave (
    input  wr_en, rd_en,
    output ws, rs, oe, full, empty, count, ovf, udf
  );
endinterface

// File: rtl/fifo_row_ctrl.sv
// Pointer/flag controller for a register-row FIFO: one-hot row strobes,
// occupancy, full/empty and sticky overflow/underflow.
module fifo_row_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           clk,
  input  logic           clear,
  fifo_row_ctrl_if.slave bus
);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, udf_q;
  logic             full, empty;
  logic             wr_ok, rd_ok, head_vld;
  logic [DEPTH-1:0] ws_dec, oe_dec;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ok    = bus.wr_en & ~full & clear;
  assign rd_ok    = bus.rd_en & ~empty & clear;
  assign head_vld = ~empty & clear;

  // Per-row decode; the head row keeps driving the bus while not empty.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    assign ws_dec[i] = wr_ok    & (wptr_q == AW'(i));
    assign oe_dec[i] = head_vld & (rptr_q == AW'(i));
  end

  always_comb begin
    wptr_d  = wptr_q + AW'(wr_ok);
    rptr_d  = rptr_q + AW'(rd_ok);
    count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_q | (bus.wr_en & full);
      udf_q   <= udf_q | (bus.rd_en & empty);
    end
  end

  assign bus.ws    = ws_dec;
  assign bus.rs    = oe_dec;
  assign bus.oe    = oe_dec;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;

endmodule

// File: tb/tb_fifo_row_ctrl.sv
// Table-driven directed vectors followed by random traffic against an
// occupancy model built from total push/pop counts.
module tb_fifo_row_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] ws;
    logic [7:0] oe;
    logic [3:0] cnt;
    logic       fl, em, ov, ud;
  } vec_t;

  logic clk = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  fifo_row_ctrl_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  fifo_row_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic clr, input logic [7:0] ws,
                     input logic [7:0] oe, input logic [3:0] cnt, input logic fl,
                     input logic em, input logic ov, input logic ud);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.ws = ws; v.oe = oe; v.cnt = cnt;
    v.fl = fl; v.em = em; v.ov = ov; v.ud = ud;
    tbl.push_back(v);
  endtask

  // Model state: pointers derive from lifetime push/pop totals.
  int m_wt, m_rt, m_cnt;
  bit m_ovf, m_udf;

  function automatic logic [7:0] onehot(input int idx);
    logic [7:0] r;
    r = '0;
    r[idx % DEPTH] = 1'b1;
    return r;
  endfunction

  initial begin
    logic wr, rd, clr;
    logic [7:0] ews, eoe;
    bit wok, rok;

    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    // reset and idle
    add(0,0,0, 8'h00, 8'h00, 0, 0,1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,1, 8'h00, 8'h00, 0, 0,1,0,0);
    // fill to full
    for (int i = 0; i < 8; i++) add(1,0,1, onehot(i), 8'h01, 4'(i+1), i==7, 0,0,0);
    // push while full
    add(1,0,1, 8'h00, 8'h01, 8, 1,0,1,0);
    // drain
    for (int j = 0; j < 8; j++)
      add(0,1,1, 8'h00, (j < 7) ? onehot(j+1) : 8'h00, 4'(7-j), 0, j==7, 1,0);
    // pointer wrap: push 6, pop 6, push 4
    add(0,0,0, 8'h00, 8'h00, 0, 0,1,0,0);
    for (int k = 0; k < 6; k++) add(1,0,1, onehot(k), 8'h01, 4'(k+1), 0,0,0,0);
    for (int k = 0; k < 6; k++)
      add(0,1,1, 8'h00, (k < 5) ? onehot(k+1) : 8'h00, 4'(5-k), 0, k==5, 0,0);
    for (int k = 0; k < 4; k++) add(1,0,1, onehot(6+k), 8'h40, 4'(k+1), 0,0,0,0);
    // push+pop together at count 3
    add(0,1,1, 8'h00, 8'h80, 3, 0,0,0,0);
    add(1,1,1, 8'h04, 8'h01, 3, 0,0,0,0);
    // push+pop together when full
    add(0,0,0, 8'h00, 8'h00, 0, 0,1,0,0);
    for (int i = 0; i < 8; i++) add(1,0,1, onehot(i), 8'h01, 4'(i+1), i==7, 0,0,0);
    add(1,1,1, 8'h00, 8'h02, 7, 0,0,1,0);
    // push+pop together when empty
    add(0,0,0, 8'h00, 8'h00, 0, 0,1,0,0);
    add(1,1,1, 8'h01, 8'h01, 1, 0,0,0,1);
    // reset mid-stream at count 5 with a push pending; flags also clear
    add(0,0,0, 8'h00, 8'h00, 0, 0,1,0,0);
    add(0,1,1, 8'h00, 8'h00, 0, 0,1,0,1);
    for (int i = 0; i < 5; i++) add(1,0,1, onehot(i), 8'h01, 4'(i+1), 0,0,0,1);
    add(1,0,0, 8'h00, 8'h00, 0, 0,1,0,0);

    foreach (tbl[n]) begin
      @(negedge clk);
      bus.wr_en = tbl[n].wr;
      bus.rd_en = tbl[n].rd;
      clear     = tbl[n].clr;
      #1;
      chk($sformatf("ws[%0d]", n), 32'(bus.ws), 32'(tbl[n].ws));
      @(posedge clk);
      #1;
      chk($sformatf("oe[%0d]", n),    32'(bus.oe),    32'(tbl[n].oe));
      chk($sformatf("rs[%0d]", n),    32'(bus.rs),    32'(tbl[n].oe));
      chk($sformatf("count[%0d]", n), 32'(bus.count), 32'(tbl[n].cnt));
      chk($sformatf("flags[%0d]", n),
          {28'd0, bus.full, bus.empty, bus.ovf, bus.udf},
          {28'd0, tbl[n].fl, tbl[n].em, tbl[n].ov, tbl[n].ud});
    end

    // random traffic; first cycle is a reset to sync the model
    m_wt = 0; m_rt = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 45);
      clr = (c != 0) && ($urandom_range(0, 99) >= 2);
      bus.wr_en = wr;
      bus.rd_en = rd;
      clear     = clr;
      #1;
      ews = (clr && wr && m_cnt < DEPTH) ? onehot(m_wt) : 8'h00;
      chk("rnd_ws", 32'(bus.ws), 32'(ews));
      if (!clr) begin
        m_wt = 0; m_rt = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
      end else begin
        wok = wr && (m_cnt < DEPTH);
        rok = rd && (m_cnt > 0);
        if (wr && m_cnt == DEPTH) m_ovf = 1;
        if (rd && m_cnt == 0)     m_udf = 1;
        m_wt  += int'(wok);
        m_rt  += int'(rok);
        m_cnt += int'(wok) - int'(rok);
      end
      @(posedge clk);
      #1;
      eoe = (m_cnt > 0) ? onehot(m_rt) : 8'h00;
      chk("rnd_oe",    32'(bus.oe),    32'(eoe));
      chk("rnd_rs",    32'(bus.rs),    32'(eoe));
      chk("rnd_count", 32'(bus.count), 32'(m_cnt));
      chk("rnd_flags", {28'd0, bus.full, bus.empty, bus.ovf, bus.udf},
          {28'd0, m_cnt == DEPTH, m_cnt == 0, m_ovf, m_udf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
